// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: opcode map, opcode field
// position, the bubble instruction and the fetch FSM state encoding.
package fetch_unit_pkg;

  localparam logic [3:0] OP_LOAD   = 4'b0000;
  localparam logic [3:0] OP_STORE  = 4'b0001;
  localparam logic [3:0] OP_JUMP   = 4'b0010;
  localparam logic [3:0] OP_BUBBLE = 4'b0011;
  localparam logic [3:0] OP_BRZ    = 4'b0100;
  localparam logic [3:0] OP_CTYPE  = 4'b1000;
  localparam logic [3:0] OP_ADDI   = 4'b1100;
  localparam logic [3:0] OP_SUBI   = 4'b1101;
  localparam logic [3:0] OP_ANDI   = 4'b1110;
  localparam logic [3:0] OP_ORI    = 4'b1111;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;

  localparam logic [15:0] NOP_INSTR = 16'h3000;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus between the fetch stage, instruction memory, the control unit and the
// branch/jump redirect logic. master = fetch stage, slave = its environment.
interface fetch_unit_if #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 16
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic [INSTR_W-1:0] instr;
  logic [3:0]         opcode;
  logic [ADDR_W-1:0]  pc_out;
  logic [ADDR_W-1:0]  pc_plus1;
  logic               instr_valid;
  logic               instr_ready;

  logic               redirect;
  logic [ADDR_W-1:0]  redirect_target;
  logic [15:0]        instr_count;

  modport master (
    output imem_req, imem_addr, instr, opcode, pc_out, pc_plus1,
           instr_valid, instr_count,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, pc_out, pc_plus1,
           instr_valid, instr_count,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_target
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, holds the fetched
// word in the instruction register and hands it to the control unit.
module fetch_unit #(
  parameter int                 ADDR_W    = 12,
  parameter int                 INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  import fetch_unit_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic [ADDR_W-1:0]  redir_pc_q, redir_pc_d;
  logic               pend_q, pend_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [15:0]        cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      pend_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address holders only matter once written, so they carry no reset.
  always_ff @(posedge clk) begin
    pc_out_q   <= pc_out_d;
    redir_pc_q <= redir_pc_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_out_d   = pc_out_q;
    redir_pc_d = redir_pc_q;
    pend_d     = pend_q;
    instr_d    = instr_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      FETCH: begin
        if (bus.imem_ack) begin
          if (bus.redirect) begin
            pc_d   = bus.redirect_target;
            pend_d = 1'b0;
          end else if (pend_q) begin
            pc_d   = redir_pc_q;
            pend_d = 1'b0;
          end else begin
            instr_d  = bus.imem_rdata;
            pc_out_d = pc_q;
            state_d  = ISSUE;
          end
        end else if (bus.redirect) begin
          // imem_addr must not move mid-request; park the target until ack.
          redir_pc_d = bus.redirect_target;
          pend_d     = 1'b1;
        end
      end

      ISSUE: begin
        if (bus.instr_ready) begin
          cnt_d = cnt_q + 16'd1;
        end
        if (bus.redirect) begin
          pc_d    = bus.redirect_target;
          state_d = FETCH;
        end else if (bus.instr_ready) begin
          pc_d    = pc_out_q + ADDR_W'(1);
          state_d = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    bus.imem_req    = (state_q == FETCH) && !rst;
    bus.imem_addr   = pc_q;
    bus.instr_valid = (state_q == ISSUE);
    bus.instr       = instr_q;
    bus.opcode      = (state_q == ISSUE) ? instr_q[OPC_HI:OPC_LO] : OP_BUBBLE;
    bus.pc_out      = pc_out_q;
    bus.pc_plus1    = pc_out_q + ADDR_W'(1);
    bus.instr_count = cnt_q;
  end

endmodule
